// File: rtl/me_best_match.sv
// Best-match tracker for full-search motion estimation.
// Rebuilds candidate positions from the scan order and keeps the minimum SAD and its MV.
module me_best_match #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int SNAKE      = 1,
  localparam int N     = SEARCH_DIM - MACRO_DIM + 1,
  localparam int OFF   = (SEARCH_DIM - MACRO_DIM) / 2,
  localparam int MV_W  = $clog2(N) + 1,
  localparam int CNT_W = $clog2(N * N) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SAD_W-1:0] thresh,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SAD_W-1:0] min_sad,
  output logic [MV_W-1:0]  mv_x,
  output logic [MV_W-1:0]  mv_y,
  output logic             early,
  output logic [CNT_W-1:0] cand_cnt
);

  localparam int POS_W = MV_W - 1;
  localparam logic [POS_W-1:0] PMAX = POS_W'(N - 1);
  localparam logic [POS_W-1:0] POFF = POS_W'(OFF);
  localparam logic [MV_W-1:0]  MOFF = MV_W'(OFF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N * N - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(N * N);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    HOLD
  } state_t;

  state_t           state;
  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic [SAD_W-1:0] thr;

  logic go;
  logic rev;
  logic col_end;
  logic at_zero;
  logic hit;
  logic better;
  logic last;

  assign go = start &&
    (state == IDLE || (state == HOLD && res_ready));

  // odd columns scan upward in snake mode
  assign rev     = (SNAKE != 0) && x[0];
  assign col_end = rev ? (y == '0) : (y == PMAX);
  assign at_zero = (x == POFF) && (y == POFF);
  assign hit     = (thr != '0) && (sad < thr);
  assign better  = (sad < min_sad) ||
    ((sad == min_sad) && at_zero);
  assign last    = (cand_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      early     <= 1'b0;
      cand_cnt  <= '0;
      min_sad   <= '1;
      mv_x      <= '0;
      mv_y      <= '0;
      x         <= '0;
      y         <= '0;
      thr       <= '0;
    end else if (go) begin
      state     <= SEARCH;
      busy      <= 1'b1;
      res_valid <= 1'b0;
      early     <= 1'b0;
      cand_cnt  <= '0;
      min_sad   <= '1;
      x         <= '0;
      y         <= '0;
      thr       <= thresh;
    end else begin
      case (state)
        SEARCH: begin
          if (sad_valid) begin
            if (cand_cnt != FULL)
              cand_cnt <= cand_cnt + 1'b1;
            if (hit || better) begin
              min_sad <= sad;
              mv_x    <= {1'b0, x} - MOFF;
              mv_y    <= {1'b0, y} - MOFF;
            end
            if (hit)
              early <= 1'b1;
            if (hit || last) begin
              state     <= HOLD;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end
            if (col_end) begin
              x <= x + 1'b1;
              y <= ((SNAKE != 0) && !x[0]) ? PMAX : '0;
            end else begin
              y <= rev ? y - 1'b1 : y + 1'b1;
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_me_best_match.sv
// Scoreboard bench for me_best_match.
// Expected results come from a position/compare model of the scan.
module tb_me_best_match;

  localparam int N  = 33;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sad_valid = 1'b0;
  logic        res_ready = 1'b1;
  logic [15:0] thresh = '0;
  logic [15:0] sad = '0;
  logic        busy;
  logic        res_valid;
  logic        early;
  logic [15:0] min_sad;
  logic [6:0]  mv_x;
  logic [6:0]  mv_y;
  logic [11:0] cand_cnt;

  typedef struct {
    logic [15:0] s;
    logic [6:0]  mx;
    logic [6:0]  my;
    logic        e;
    logic [11:0] c;
  } res_t;

  res_t        q[$];
  res_t        got_e;
  res_t        held;
  int          checks = 0;
  int          errors = 0;
  int          n_res = 0;
  logic [15:0] sads[NN];

  me_best_match dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .thresh   (thresh),
    .sad_valid(sad_valid),
    .sad      (sad),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .min_sad  (min_sad),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .early    (early),
    .cand_cnt (cand_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] thr);
    res_t r;
    int   x;
    int   y;
    r.s  = 16'hFFFF;
    r.mx = '0;
    r.my = '0;
    r.e  = 1'b0;
    r.c  = 12'(NN);
    for (int k = 0; k < NN; k++) begin
      x = k / N;
      y = (x % 2 == 1) ? N - 1 - (k % N) : k % N;
      if (thr != 0 && sads[k] < thr) begin
        r.s  = sads[k];
        r.mx = 7'(x - 16);
        r.my = 7'(y - 16);
        r.e  = 1'b1;
        r.c  = 12'(k + 1);
        return r;
      end
      if (sads[k] < r.s ||
          (sads[k] == r.s && x == 16 && y == 16)) begin
        r.s  = sads[k];
        r.mx = 7'(x - 16);
        r.my = 7'(y - 16);
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      chk("q_nonempty", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        got_e = q.pop_front();
        chk("min_sad", min_sad, got_e.s);
        chk("mv_x", mv_x, got_e.mx);
        chk("mv_y", mv_y, got_e.my);
        chk("early", early, got_e.e);
        chk("cand_cnt", cand_cnt, got_e.c);
      end
      n_res++;
    end
  end

  task automatic fill(input logic [15:0] v);
    for (int k = 0; k < NN; k++) sads[k] = v;
  endtask

  task automatic pulse_start(input logic [15:0] thr);
    thresh = thr;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  task automatic stream(input int n, input bit pulses);
    for (int i = 0; i < n; i++) begin
      sad_valid = 1'b1;
      sad       = sads[i];
      start     = pulses && (i % 100 == 50);
      @(posedge clk);
      #1;
    end
    sad_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_res(input int target);
    for (int i = 0; i < 40 && n_res < target; i++)
      @(posedge clk);
    #1;
    chk("res_count", n_res, target);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_early", early, 0);
    chk("rst_cnt", cand_cnt, 0);
    chk("rst_min", min_sad, 16'hFFFF);
    chk("rst_mvx", mv_x, 0);
    chk("rst_mvy", mv_y, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    fill(16'd500);
    sads[40] = 16'd12;
    q.push_back(model(16'd0));
    pulse_start(16'd0);
    chk("t1_busy", busy, 1);
    stream(NN, 1'b0);
    chk("t1_rv", res_valid, 1);
    wait_res(1);

    fill(16'd300);
    sads[544] = 16'd301;
    q.push_back(model(16'd0));
    pulse_start(16'd0);
    stream(NN, 1'b0);
    wait_res(2);

    fill(16'd300);
    q.push_back(model(16'd0));
    pulse_start(16'd0);
    stream(NN, 1'b0);
    wait_res(3);

    fill(16'd500);
    sads[5] = 16'd7;
    held = model(16'd20);
    res_ready = 1'b0;
    pulse_start(16'd20);
    stream(6, 1'b0);
    chk("t3_rv", res_valid, 1);
    chk("t3_early", early, 1);
    chk("t3_cnt", cand_cnt, 6);
    stream(10, 1'b0);
    chk("t3_ign_cnt", cand_cnt, 6);
    for (int i = 0; i < 10; i++) begin
      chk("t4_rv", res_valid, 1);
      chk("t4_min", min_sad, held.s);
      chk("t4_mvx", mv_x, held.mx);
      chk("t4_mvy", mv_y, held.my);
      @(posedge clk);
      #1;
    end
    q.push_back(held);
    fill(16'd500);
    sads[40] = 16'd12;
    q.push_back(model(16'd0));
    res_ready = 1'b1;
    thresh    = 16'd0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t4_busy", busy, 1);
    chk("t4_rv_lo", res_valid, 0);
    chk("t4_cnt0", cand_cnt, 0);
    chk("t4_min1", min_sad, 16'hFFFF);
    chk("t4_nres", n_res, 4);
    stream(NN, 1'b1);
    wait_res(5);

    pulse_start(16'd0);
    stream(500, 1'b0);
    chk("t6_cnt", cand_cnt, 500);
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_cnt0", cand_cnt, 0);
    chk("t6_min", min_sad, 16'hFFFF);
    chk("t6_rv", res_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.push_back(model(16'd0));
    pulse_start(16'd0);
    stream(NN, 1'b0);
    wait_res(6);
    chk("q_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
